// File: rtl/input_pkg.sv
// Shared types and sizing helpers for the input conditioner.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } ch_state_e;

  // Width that holds 0..n inclusive; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw button inputs and conditioned event outputs for all channels.
interface input_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] release_p;
  logic [CHANNELS-1:0] repeat_p;

  modport master (output din, input level, press, release_p, repeat_p);
  modport slave  (input din, output level, press, release_p, repeat_p);
endinterface

// File: rtl/input_channel.sv
// One button channel: synchroniser, debounce filter and press/repeat/release FSM.
module input_channel
  import input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic release_p,
  output logic repeat_p
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sy;
  logic [DW-1:0]          dcnt;
  logic                   toggle, rise, fall;
  ch_state_e              state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   press_d, release_d, repeat_d;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign sy = sync[SYNC_STAGES-1];

  // The edge on which the count would reach its terminal value flips level
  // directly, so the FSM sees the flip as a combinational event.
  assign toggle = (sy != level) && (dcnt == D_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  always_ff @(posedge clk) begin
    if (rst)                      dcnt <= '0;
    else if (sy == level || toggle) dcnt <= '0;
    else                          dcnt <= dcnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)         level <= 1'b0;
    else if (toggle) level <= ~level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      press     <= 1'b0;
      release_p <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press     <= press_d;
      release_p <= release_d;
      repeat_p  <= repeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = DELAY;
      DELAY: begin
        if (fall)                                         state_d = IDLE;
        else if (REPEAT_DELAY != 0 && rcnt_q == RD_LAST) state_d = REPEAT;
      end
      REPEAT:  if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A falling level wins over any repeat due on the same edge.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    rcnt_d    = rcnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (fall) begin
          release_d = 1'b1;
          rcnt_d    = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rcnt_q == RD_LAST) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          rcnt_d    = '0;
        end else if (rcnt_q == RP_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: rcnt_d = '0;
    endcase
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button conditioner: one independent input_channel per input bit.
module input_conditioner
  import input_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input logic          clk,
  input logic          rst,
  input_conditioner_if.slave bus
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .din      (bus.din[c]),
      .level    (bus.level[c]),
      .press    (bus.press[c]),
      .release_p(bus.release_p[c]),
      .repeat_p (bus.repeat_p[c])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: two conditioners (auto-repeat on / off) fed the same inputs.
module tb_input_conditioner;
  localparam int CH   = 4;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int RD_A = 8;
  localparam int RD_B = 0;
  localparam int P    = 3;

  typedef struct {
    int           n;
    logic [CH-1:0] lvl;
    logic [CH-1:0] pr_a, rl_a, rp_a;
    logic [CH-1:0] pr_b, rl_b, rp_b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] din = '0;

  input_conditioner_if #(.CHANNELS(CH)) bus_a ();
  input_conditioner_if #(.CHANNELS(CH)) bus_b ();
  assign bus_a.din = din;
  assign bus_b.din = din;

  input_conditioner #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(P)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  input_conditioner #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(P)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  exp_t          q[$];
  logic [CH-1:0] din_log[$];
  bit            rst_log[$];
  int            checks = 0;
  int            failures = 0;

  // Reference state: debounced level per channel and the edge of the last press.
  logic [CH-1:0] m_lvl = '0;
  int            pe[CH];
  int            last_rst = -1;

  // Value seen at the synchroniser output just before edge n.
  function automatic logic sy_pre(input int c, input int n);
    if (n - S < 0) return 1'b0;
    for (int m = n - S + 1; m <= n - 1; m++)
      if (m >= 0 && rst_log[m]) return 1'b0;
    return din_log[n - S][c];
  endfunction

  function automatic bit rep_due(input int p, input int n, input int rd);
    if (rd == 0 || p < 0 || n - p < rd) return 1'b0;
    return ((n - p - rd) % P) == 0;
  endfunction

  task automatic step(input bit r, input logic [CH-1:0] d);
    exp_t e;
    int   n;
    bit   flip;
    @(negedge clk);
    rst = r;
    din = d;
    din_log.push_back(r ? '0 : d);
    rst_log.push_back(r);
    n = din_log.size() - 1;
    e = '{n: n, default: '0};
    if (r) begin
      m_lvl    = '0;
      last_rst = n;
      for (int c = 0; c < CH; c++) pe[c] = -1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        // Level flips once the last D synchronised samples since reset all disagree.
        flip = (n - D + 1 >= 0) && (n - D + 1 > last_rst);
        for (int j = 0; j < D; j++)
          if (flip && sy_pre(c, n - j) == m_lvl[c]) flip = 1'b0;
        if (flip && !m_lvl[c]) begin
          e.pr_a[c] = 1'b1; e.pr_b[c] = 1'b1;
          pe[c] = n;
        end else if (flip && m_lvl[c]) begin
          e.rl_a[c] = 1'b1; e.rl_b[c] = 1'b1;
          pe[c] = -1;
        end else if (m_lvl[c]) begin
          e.rp_a[c] = rep_due(pe[c], n, RD_A);
          e.rp_b[c] = rep_due(pe[c], n, RD_B);
        end
        if (flip) m_lvl[c] = ~m_lvl[c];
      end
    end
    e.lvl = m_lvl;
    q.push_back(e);
  endtask

  task automatic run(input bit r, input logic [CH-1:0] d, input int cycles);
    for (int i = 0; i < cycles; i++) step(r, d);
  endtask

  task automatic chk(input string name, input int n, input logic [CH-1:0] act,
                     input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, n, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("level_a",   e.n, bus_a.level,     e.lvl);
        chk("press_a",   e.n, bus_a.press,     e.pr_a);
        chk("release_a", e.n, bus_a.release_p, e.rl_a);
        chk("repeat_a",  e.n, bus_a.repeat_p,  e.rp_a);
        chk("level_b",   e.n, bus_b.level,     e.lvl);
        chk("press_b",   e.n, bus_b.press,     e.pr_b);
        chk("release_b", e.n, bus_b.release_p, e.rl_b);
        chk("repeat_b",  e.n, bus_b.repeat_p,  e.rp_b);
      end
    end
  end

  initial begin : stim
    logic [CH-1:0] cur;
    int            guard;
    for (int c = 0; c < CH; c++) pe[c] = -1;
    // Held high through reset, then release and fall.
    run(1'b1, 4'hF, 3);
    run(1'b0, 4'hF, 10);
    run(1'b0, 4'h0, 10);
    // Glitch shorter than the debounce window.
    run(1'b0, 4'h1, 3);
    run(1'b0, 4'h0, 10);
    // Long hold with auto-repeat, then release.
    run(1'b0, 4'h2, 30);
    run(1'b0, 4'h0, 10);
    // Two channels rising two cycles apart.
    run(1'b0, 4'h4, 2);
    run(1'b0, 4'hC, 10);
    run(1'b0, 4'h0, 10);
    // Long hold on channel 0.
    run(1'b0, 4'h1, 100);
    run(1'b0, 4'h0, 10);
    // Reset pulse while repeating, input still held.
    run(1'b0, 4'h2, 20);
    run(1'b1, 4'h2, 1);
    run(1'b0, 4'h2, 15);
    run(1'b0, 4'h0, 10);
    // Random sticky inputs with occasional resets.
    cur = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(9) == 0) cur[c] = ~cur[c];
      step($urandom_range(149) == 0, cur);
    end
    run(1'b0, 4'h0, 12);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
